lif_neuron_array: RTL and testbench

Parametrised multi-channel leaky integrate-and-fire neuron array. It is the successor of the single 8-bit membrane register. Each channel integrates its input current with a configurable shift-based leak, saturates instead of wrapping, compares against a shared runtime threshold, emits a registered one-cycle spike and enforces a refractory period. Updates advance only on a time-step strobe, so the array can run slower than the system clock.

---
 rtl/lif_neuron_array.sv | 87 ++++++++
 tb/tb_lif_neuron_array.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// lif_neuron_array: multi-channel leaky integrate-and-fire neurons.
// Each channel integrates its input current on top of a shift-leaked
// membrane, saturates at the full-scale value, fires a registered one-cycle
// spike when the shared threshold is reached and then stays silent for
// REFRAC time steps.
//
// Strobe semantics: there is no valid/ready handshake. 'step' is a
// time-step strobe; channel state only advances on clock edges where
// step=1. 'threshold' and 'current' are sampled on those same edges. All
// outputs come straight from registers, so there is no combinational path
// from any input to any output.
module lif_neuron_array #(
  parameter int N_CH       = 4,
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step,
  input  logic [N_CH*WIDTH-1:0]   current,
  input  logic [WIDTH-1:0]        threshold,
  output logic [N_CH*WIDTH-1:0]   state,
  output logic [N_CH-1:0]         spike,
  output logic [N_CH-1:0]         refractory
);

  // Refractory counter needs to hold REFRAC; keep at least one bit so the
  // REFRAC=0 build still has a legal (constantly zero) counter.
  localparam int CW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(REFRAC);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [WIDTH-1:0] st_q;
    logic [WIDTH-1:0] st_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             sp_q;
    logic             sp_d;
    logic             rf_q;
    logic [WIDTH:0]   acc_raw;
    logic [WIDTH-1:0] acc;

    // Next-state: leak + integrate with saturation, then refractory / fire / hold decision.
    always_comb begin
      acc_raw = {1'b0, current[i*WIDTH +: WIDTH]} + {1'b0, (st_q >> LEAK_SHIFT)};
      acc     = acc_raw[WIDTH] ? {WIDTH{1'b1}} : acc_raw[WIDTH-1:0];
      st_d    = st_q;
      cnt_d   = cnt_q;
      sp_d    = 1'b0;
      if (step) begin
        if (cnt_q != '0) begin
          // Silent period: input current is ignored entirely.
          st_d  = '0;
          cnt_d = cnt_q - CNT_ONE;
        end else if (acc >= threshold) begin
          st_d  = '0;
          sp_d  = 1'b1;
          cnt_d = CNT_LOAD;
        end else begin
          st_d  = acc;
        end
      end
    end

    // Channel registers; reset wins over step and cancels any refractory period.
    always_ff @(posedge clk) begin
      if (reset) begin
        st_q  <= '0;
        cnt_q <= '0;
        sp_q  <= 1'b0;
        rf_q  <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        sp_q  <= sp_d;
        rf_q  <= (cnt_d != '0);
      end
    end

    assign state[i*WIDTH +: WIDTH] = st_q;
    assign spike[i]                = sp_q;
    assign refractory[i]           = rf_q;
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// tb_lif_neuron_array: directed scoreboard bench for lif_neuron_array with
// default parameters (4 channels, 8 bits, leak shift 1, refractory 2).
// The driver applies one cycle of inputs at each falling edge and queues the
// hand-computed outputs expected after the following rising edge; the
// monitor pops and compares shortly after every rising edge.
module tb_lif_neuron_array;

  localparam int N_CH = 4;
  localparam int W    = 8;
  localparam int EW   = N_CH * W + 2 * N_CH;

  logic                  clk;
  logic                  reset;
  logic                  step;
  logic [N_CH*W-1:0]     current;
  logic [W-1:0]          threshold;
  logic [N_CH*W-1:0]     state;
  logic [N_CH-1:0]       spike;
  logic [N_CH-1:0]       refractory;

  logic [EW-1:0] exp_q[$];
  string         tag_q[$];
  string         tag;
  int            checks;
  int            failures;

  lif_neuron_array #(
    .N_CH(N_CH), .WIDTH(W), .LEAK_SHIFT(1), .REFRAC(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .step(step),
    .current(current),
    .threshold(threshold),
    .state(state),
    .spike(spike),
    .refractory(refractory)
  );

  // Clock and reset defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    reset     = 1'b1;
    step      = 1'b0;
    current   = '0;
    threshold = '0;
  end

  function automatic logic [N_CH*W-1:0] pk(input logic [W-1:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  // Driver: one clock of stimulus plus the outputs expected after its rising edge
  task automatic drive(input logic rst, input logic stp, input logic [N_CH*W-1:0] cur,
                       input logic [W-1:0] thr, input logic [N_CH*W-1:0] est,
                       input logic [N_CH-1:0] esp, input logic [N_CH-1:0] erf);
    @(negedge clk);
    reset     = rst;
    step      = stp;
    current   = cur;
    threshold = thr;
    exp_q.push_back({est, esp, erf});
    tag_q.push_back(tag);
  endtask

  // Monitor: compare every presented output against the head of the queue
  always @(posedge clk) begin
    logic [EW-1:0] e;
    string         t;
    #3;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (state !== e[EW-1 -: N_CH*W]) begin
        failures++;
        $display("FAIL %s state: got %h want %h", t, state, e[EW-1 -: N_CH*W]);
      end
      checks++;
      if (spike !== e[2*N_CH-1 -: N_CH]) begin
        failures++;
        $display("FAIL %s spike: got %b want %b", t, spike, e[2*N_CH-1 -: N_CH]);
      end
      checks++;
      if (refractory !== e[N_CH-1:0]) begin
        failures++;
        $display("FAIL %s refractory: got %b want %b", t, refractory, e[N_CH-1:0]);
      end
    end
  end

  // Directed stimulus
  initial begin
    logic [W-1:0] sub_exp[8];
    logic [W-1:0] sat_exp[9];
    logic [W-1:0] s_ch0[4];
    logic [3:0]   s_sp[4];
    logic [3:0]   s_rf[4];
    logic [3:0]   t0_rf[7];
    int           budget;

    checks   = 0;
    failures = 0;

    // Reset overrides step with full-scale current.
    tag = "reset";
    repeat (2) drive(1'b1, 1'b1, {N_CH{8'hFF}}, 8'd100, '0, 4'b0000, 4'b0000);
    // First step after release: acc=255 reaches threshold 255 on every channel.
    tag = "first_step";
    drive(1'b0, 1'b1, {N_CH{8'hFF}}, 8'd255, '0, 4'b1111, 4'b1111);
    tag = "reset_clear";
    drive(1'b1, 1'b0, '0, 8'd100, '0, 4'b0000, 4'b0000);

    // Subthreshold leak on ch0.
    tag = "subthreshold";
    sub_exp = '{8'd40, 8'd60, 8'd70, 8'd75, 8'd77, 8'd78, 8'd79, 8'd79};
    for (int k = 0; k < 8; k++)
      drive(1'b0, 1'b1, pk(8'd40, 0, 0, 0), 8'd100, pk(sub_exp[k], 0, 0, 0), 4'b0000, 4'b0000);

    // Fire and refractory on ch0.
    tag = "fire_reset";
    drive(1'b1, 1'b0, '0, 8'd100, '0, 4'b0000, 4'b0000);
    tag = "fire";
    drive(1'b0, 1'b1, pk(8'd60, 0, 0, 0), 8'd100, pk(8'd60, 0, 0, 0), 4'b0000, 4'b0000);
    drive(1'b0, 1'b1, pk(8'd60, 0, 0, 0), 8'd100, pk(8'd90, 0, 0, 0), 4'b0000, 4'b0000);
    drive(1'b0, 1'b1, pk(8'd60, 0, 0, 0), 8'd100, '0, 4'b0001, 4'b0001);
    tag = "refrac";
    drive(1'b0, 1'b1, pk(8'd60, 0, 0, 0), 8'd100, '0, 4'b0000, 4'b0001);
    drive(1'b0, 1'b1, pk(8'd60, 0, 0, 0), 8'd100, '0, 4'b0000, 4'b0000);
    tag = "refrac_done";
    drive(1'b0, 1'b1, pk(8'd60, 0, 0, 0), 8'd100, pk(8'd60, 0, 0, 0), 4'b0000, 4'b0000);

    // Saturation: 200 + 100 clamps to 255 and fires at threshold 255.
    tag = "sat_reset";
    drive(1'b1, 1'b0, '0, 8'd255, '0, 4'b0000, 4'b0000);
    tag = "sat_fire";
    drive(1'b0, 1'b1, pk(8'd200, 0, 0, 0), 8'd255, pk(8'd200, 0, 0, 0), 4'b0000, 4'b0000);
    drive(1'b0, 1'b1, pk(8'd200, 0, 0, 0), 8'd255, '0, 4'b0001, 4'b0001);
    tag = "sat_reset2";
    drive(1'b1, 1'b0, '0, 8'd254, '0, 4'b0000, 4'b0000);
    tag = "sat_approach";
    sat_exp = '{8'd127, 8'd190, 8'd222, 8'd238, 8'd246, 8'd250, 8'd252, 8'd253, 8'd253};
    for (int k = 0; k < 9; k++)
      drive(1'b0, 1'b1, pk(8'd127, 0, 0, 0), 8'd254, pk(sat_exp[k], 0, 0, 0), 4'b0000, 4'b0000);

    // Strobe gating and channel independence: step once every four cycles.
    tag = "gate_reset";
    drive(1'b1, 1'b0, '0, 8'd100, '0, 4'b0000, 4'b0000);
    s_ch0 = '{8'd60, 8'd90, 8'd0, 8'd0};
    s_sp  = '{4'b0100, 4'b0000, 4'b0001, 4'b0100};
    s_rf  = '{4'b0100, 4'b0100, 4'b0001, 4'b0101};
    for (int s = 0; s < 4; s++) begin
      tag = "gate_step";
      drive(1'b0, 1'b1, pk(8'd60, 8'd0, 8'd255, 8'd0), 8'd100, pk(s_ch0[s], 0, 0, 0), s_sp[s], s_rf[s]);
      tag = "gate_idle";
      repeat (3)
        drive(1'b0, 1'b0, pk(8'd60, 8'd0, 8'd255, 8'd0), 8'd100, pk(s_ch0[s], 0, 0, 0), 4'b0000, s_rf[s]);
    end

    // Reset in the middle of a refractory period, then threshold 0.
    tag = "midref_reset";
    drive(1'b1, 1'b0, '0, 8'd100, '0, 4'b0000, 4'b0000);
    tag = "midref_fire";
    drive(1'b0, 1'b1, pk(8'd60, 0, 0, 0), 8'd100, pk(8'd60, 0, 0, 0), 4'b0000, 4'b0000);
    drive(1'b0, 1'b1, pk(8'd60, 0, 0, 0), 8'd100, pk(8'd90, 0, 0, 0), 4'b0000, 4'b0000);
    drive(1'b0, 1'b1, pk(8'd60, 0, 0, 0), 8'd100, '0, 4'b0001, 4'b0001);
    tag = "midref_clear";
    drive(1'b1, 1'b1, pk(8'd60, 0, 0, 0), 8'd100, '0, 4'b0000, 4'b0000);
    tag = "thr_zero";
    t0_rf = '{4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b1111};
    for (int k = 0; k < 7; k++)
      drive(1'b0, 1'b1, '0, 8'd0, '0, ((k % 3) == 0) ? 4'b1111 : 4'b0000, t0_rf[k]);

    // Drain the scoreboard with a bounded wait.
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #5;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
